// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 direction decoder: scan codes, one-hot
// direction encodings and the frame receiver state type.
package ps2_pkg;

  // Prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] PS2_ARROW_UP    = 8'h75;
  localparam logic [7:0] PS2_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] PS2_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_ARROW_RIGHT = 8'h74;

  // Plain WASD keys
  localparam logic [7:0] PS2_KEY_W = 8'h1D;
  localparam logic [7:0] PS2_KEY_S = 8'h1B;
  localparam logic [7:0] PS2_KEY_A = 8'h1C;
  localparam logic [7:0] PS2_KEY_D = 8'h23;

  // One-hot direction encodings as consumed by the game core
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  // Device-to-host frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // Map a completed key code to a direction; DIR_NONE when the code is not
  // a steering key in the current (extended or plain) code page.
  function automatic logic [3:0] key_to_dir(input logic ext, input logic [7:0] code);
    logic [3:0] dir;
    dir = DIR_NONE;
    if (ext) begin
      case (code)
        PS2_ARROW_UP:    dir = DIR_UP;
        PS2_ARROW_DOWN:  dir = DIR_DOWN;
        PS2_ARROW_LEFT:  dir = DIR_LEFT;
        PS2_ARROW_RIGHT: dir = DIR_RIGHT;
        default:         dir = DIR_NONE;
      endcase
    end else begin
      case (code)
        PS2_KEY_W: dir = DIR_UP;
        PS2_KEY_S: dir = DIR_DOWN;
        PS2_KEY_A: dir = DIR_LEFT;
        PS2_KEY_D: dir = DIR_RIGHT;
        default:   dir = DIR_NONE;
      endcase
    end
    return dir;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes the open-collector lines,
// glitch-filters the PS/2 clock, detects its falling edges and deserializes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) with an
// inter-edge timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 106470000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Ps2Clk,
  input  logic       i_Ps2Data,
  output logic [7:0] o_Byte,
  output logic       o_Valid,
  output logic       o_Error
);

  localparam int unsigned TO_TICKS = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int unsigned TO_W     = $clog2(TO_TICKS + 1);
  localparam int unsigned FLT_W    = $clog2(FILTER_LEN + 1);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_TICKS);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  // ---------------------------------------------------------------------
  // Two-flop synchronizers, index 0 = PS/2 clock, index 1 = PS/2 data.
  // Both lines idle high, so the chain resets high to avoid a false edge.
  // ---------------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] meta_q;
  logic [1:0] sync_q;

  assign raw_in = {i_Ps2Data, i_Ps2Clk};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    // Two-stage metastability filter for one asynchronous line
    always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
        meta_q[gi] <= 1'b1;
        sync_q[gi] <= 1'b1;
      end else begin
        meta_q[gi] <= raw_in[gi];
        sync_q[gi] <= meta_q[gi];
      end
    end
  end

  logic ps2_clk_s;
  logic ps2_data_s;
  assign ps2_clk_s  = sync_q[0];
  assign ps2_data_s = sync_q[1];

  // ---------------------------------------------------------------------
  // Glitch filter: the filtered clock follows the synchronized clock only
  // after FILTER_LEN consecutive samples disagree with the current level.
  // ---------------------------------------------------------------------
  logic             flt_q, flt_d;
  logic [FLT_W-1:0] fcnt_q, fcnt_d;
  logic             flt_prev_q;
  logic             fall;

  // Count consecutive disagreeing samples; any agreeing sample restarts it
  always_comb begin
    flt_d  = flt_q;
    fcnt_d = '0;
    if (ps2_clk_s != flt_q) begin
      if (fcnt_q == FLT_LAST) begin
        flt_d = ps2_clk_s;
      end else begin
        fcnt_d = fcnt_q + FLT_W'(1);
      end
    end
  end

  // Filter level, run counter and one-cycle-delayed copy for edge detection
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      flt_q      <= 1'b1;
      fcnt_q     <= '0;
      flt_prev_q <= 1'b1;
    end else begin
      flt_q      <= flt_d;
      fcnt_q     <= fcnt_d;
      flt_prev_q <= flt_q;
    end
  end

  assign fall = flt_prev_q & ~flt_q;

  // ---------------------------------------------------------------------
  // Frame FSM with timeout. Results are registered so valid/error pulse on
  // the cycle after the stop-bit edge.
  // ---------------------------------------------------------------------
  frame_state_e    state_q, state_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_q, to_d;

  // Next-state, shift register, timeout and result pulses
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    // The timeout only runs while a frame is in progress and restarts on
    // every edge.
    if (state_q == ST_IDLE || fall) begin
      to_d = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (fall && !ps2_data_s) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d = {ps2_data_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = ps2_data_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (ps2_data_s && (^{shift_q, par_q})) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Stalled frame: abandon it. An edge in the same cycle takes priority.
    if (state_q != ST_IDLE && !fall && to_q == TO_LAST) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      to_d    = '0;
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_IDLE;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign o_Byte  = byte_q;
  assign o_Valid = valid_q;
  assign o_Error = err_q;

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard to one-hot game direction. The receiver delivers bytes;
// this level tracks the E0/F0 prefixes and turns completed arrow or WASD
// key presses into a held direction. Key releases are ignored.
module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 106470000,
  parameter int unsigned TIMEOUT_US  = 2000,
  parameter int unsigned FILTER_LEN  = 8,
  parameter logic [3:0]  DEFAULT_DIR = 4'b1000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Ps2Clk,
  input  logic       i_Ps2Data,
  output logic [3:0] o_Direction,
  output logic       o_DirValid,
  output logic [7:0] o_ScanCode,
  output logic       o_ScanValid,
  output logic       o_FrameError
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;

  ps2_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .TIMEOUT_US(TIMEOUT_US),
    .FILTER_LEN(FILTER_LEN)
  ) u_rx (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Ps2Clk (i_Ps2Clk),
    .i_Ps2Data(i_Ps2Data),
    .o_Byte   (rx_byte),
    .o_Valid  (rx_valid),
    .o_Error  (rx_error)
  );

  logic [3:0] dir_q, dir_d;
  logic       dir_valid_q, dir_valid_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [3:0] key_dir;

  assign key_dir = key_to_dir(ext_q, rx_byte);

  // Prefix tracking and direction update for each received byte
  always_comb begin
    dir_d       = dir_q;
    dir_valid_d = 1'b0;
    ext_d       = ext_q;
    brk_d       = brk_q;

    if (rx_error) begin
      // A corrupted byte may have been part of a prefixed sequence
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      case (rx_byte)
        PS2_EXT:   ext_d = 1'b1;
        PS2_BREAK: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!brk_q && key_dir != DIR_NONE) begin
            dir_d       = key_dir;
            dir_valid_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Decoder registers
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      dir_q       <= DEFAULT_DIR;
      dir_valid_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
    end
  end

  assign o_Direction  = dir_q;
  assign o_DirValid   = dir_valid_q;
  assign o_ScanCode   = rx_byte;
  assign o_ScanValid  = rx_valid;
  assign o_FrameError = rx_error;

endmodule
